// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared Pong types, playfield defaults and position step helper
// Contents: ball_state_t (ball FSM states), vel_t (speed magnitude plus direction bit),
// default playfield bounds shared with the paddle controllers, step_pos() helper.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_HOLD,
        ST_GAME_OVER
    } ball_state_t;

    // dir = 1 means moving right (x) or down (y)
    typedef struct packed {
        logic [3:0] mag;
        logic       dir;
    } vel_t;

    localparam logic [9:0] DEF_Y_CEIL   = 10'd0;
    localparam logic [9:0] DEF_Y_FLOOR  = 10'd479;
    localparam logic [9:0] DEF_X_LWALL  = 10'd0;
    localparam logic [9:0] DEF_X_RWALL  = 10'd639;
    localparam logic [7:0] DEF_PADDLE_H = 8'd80;

    // One-tick advance on an 11-bit intermediate; a step past zero clamps to
    // zero so the ball can never wrap to the far side of the field.
    function automatic logic [10:0] step_pos(input logic [9:0] pos, input vel_t v);
        logic [10:0] p;
        logic [10:0] m;
        p = {1'b0, pos};
        m = {7'd0, v.mag};
        if (v.dir) begin
            return p + m;
        end
        if (p < m) begin
            return 11'd0;
        end
        return p - m;
    endfunction

endpackage

// File: rtl/ball_hit_detect.sv
// rtl/ball_hit_detect.sv - combinational wall, paddle and miss detection for the ball
// Inputs:  ball_x/ball_y current position, next_x/next_y candidate position (11 bit),
//          dir_x (1 = moving right), playfield bounds, paddle corners, height_paddle.
// Outputs: hit_ceil, hit_floor, hit_left, hit_right, miss_left, miss_right.
module ball_hit_detect #(
    parameter int BALL_SIZE = 8,
    parameter int PADDLE_W  = 10
) (
    input  logic [9:0]  ball_x,
    input  logic [9:0]  ball_y,
    input  logic [10:0] next_x,
    input  logic [10:0] next_y,
    input  logic        dir_x,
    input  logic [9:0]  y_ceil,
    input  logic [9:0]  y_floor,
    input  logic [9:0]  x_lwall,
    input  logic [9:0]  x_rwall,
    input  logic [9:0]  paddle_x_l,
    input  logic [9:0]  paddle_y_l,
    input  logic [9:0]  paddle_x_r,
    input  logic [9:0]  paddle_y_r,
    input  logic [7:0]  height_paddle,
    output logic        hit_ceil,
    output logic        hit_floor,
    output logic        hit_left,
    output logic        hit_right,
    output logic        miss_left,
    output logic        miss_right
);
    localparam logic [10:0] BS = 11'(BALL_SIZE);
    localparam logic [10:0] PW = 11'(PADDLE_W);

    logic [10:0] cur_x;
    logic [10:0] cur_y;
    logic [10:0] face_l;
    logic [10:0] hgt;
    logic        overlap_l;
    logic        overlap_r;

    always_comb begin
        cur_x  = {1'b0, ball_x};
        cur_y  = {1'b0, ball_y};
        face_l = {1'b0, paddle_x_l} + PW;
        hgt    = {3'd0, height_paddle};

        hit_ceil  = next_y <= {1'b0, y_ceil};
        hit_floor = !hit_ceil && (next_y + BS >= {1'b0, y_floor});

        // Vertical overlap uses the current y so a same-tick wall bounce
        // does not change whether the paddle is struck.
        overlap_l = (cur_y + BS > {1'b0, paddle_y_l}) && (cur_y < {1'b0, paddle_y_l} + hgt);
        overlap_r = (cur_y + BS > {1'b0, paddle_y_r}) && (cur_y < {1'b0, paddle_y_r} + hgt);

        // A hit needs the leading edge to cross the paddle face this tick.
        hit_left  = !dir_x && (cur_x >= face_l) && (next_x < face_l) && overlap_l;
        hit_right = dir_x && (cur_x + BS <= {1'b0, paddle_x_r})
                    && (next_x + BS > {1'b0, paddle_x_r}) && overlap_r;

        miss_left  = !hit_left && !hit_right && (next_x <= {1'b0, x_lwall});
        miss_right = !hit_left && !hit_right && !miss_left && (next_x + BS >= {1'b0, x_rwall});
    end

endmodule

// File: rtl/ball_collision_controller.sv
// rtl/ball_collision_controller.sv - Pong ball motion, reflection, scoring and serve/hold/game-over FSM
// Inputs:  game_clk, reset (sync, active high), serve, playfield bounds, paddle corners, height_paddle.
// Outputs: ball_x/ball_y, score_l/score_r, point (one-tick pulse), game_over (level).
// Option:  BALL_SPEEDUP_EN - each paddle hit adds 1 to x speed, capped at MAX_VX.
module ball_collision_controller
    import pong_pkg::*;
#(
    parameter int BALL_SIZE  = 8,
    parameter int PADDLE_W   = 10,
    parameter int CENTER_X   = 316,
    parameter int CENTER_Y   = 236,
    parameter int INIT_VX    = 2,
    parameter int INIT_VY    = 1,
    parameter int MAX_VX     = 8,
    parameter int HOLD_TICKS = 60,
    parameter int WIN_SCORE  = 5
) (
    input  logic       game_clk,
    input  logic       reset,
    input  logic       serve,
    input  logic [9:0] y_ceil,
    input  logic [9:0] y_floor,
    input  logic [9:0] x_lwall,
    input  logic [9:0] x_rwall,
    input  logic [9:0] paddle_x_l,
    input  logic [9:0] paddle_y_l,
    input  logic [9:0] paddle_x_r,
    input  logic [9:0] paddle_y_r,
    input  logic [7:0] height_paddle,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       point,
    output logic       game_over
);
    localparam logic [9:0] CX = 10'(CENTER_X);
    localparam logic [9:0] CY = 10'(CENTER_Y);
    localparam logic [9:0] BS = 10'(BALL_SIZE);
    localparam logic [9:0] PW = 10'(PADDLE_W);
    localparam logic [3:0] WIN = 4'(WIN_SCORE);
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS - 1);

    ball_state_t       state;
    vel_t              vx;
    vel_t              vy;
    logic              serve_dir;
    logic [HOLD_W-1:0] hold_cnt;

    logic [10:0] next_x;
    logic [10:0] next_y;
    logic        hit_ceil, hit_floor, hit_left, hit_right, miss_left, miss_right;
    logic [3:0]  vx_mag_hit;
    logic [3:0]  score_l_inc;
    logic [3:0]  score_r_inc;

    always_comb begin
        next_x = step_pos(ball_x, vx);
        next_y = step_pos(ball_y, vy);
`ifdef BALL_SPEEDUP_EN
        vx_mag_hit = (vx.mag >= 4'(MAX_VX)) ? 4'(MAX_VX) : vx.mag + 4'd1;
`else
        vx_mag_hit = 4'(INIT_VX);
`endif
        score_l_inc = (score_l >= WIN) ? WIN : score_l + 4'd1;
        score_r_inc = (score_r >= WIN) ? WIN : score_r + 4'd1;
    end

    ball_hit_detect #(
        .BALL_SIZE (BALL_SIZE),
        .PADDLE_W  (PADDLE_W)
    ) u_hit (
        .ball_x        (ball_x),
        .ball_y        (ball_y),
        .next_x        (next_x),
        .next_y        (next_y),
        .dir_x         (vx.dir),
        .y_ceil        (y_ceil),
        .y_floor       (y_floor),
        .x_lwall       (x_lwall),
        .x_rwall       (x_rwall),
        .paddle_x_l    (paddle_x_l),
        .paddle_y_l    (paddle_y_l),
        .paddle_x_r    (paddle_x_r),
        .paddle_y_r    (paddle_y_r),
        .height_paddle (height_paddle),
        .hit_ceil      (hit_ceil),
        .hit_floor     (hit_floor),
        .hit_left      (hit_left),
        .hit_right     (hit_right),
        .miss_left     (miss_left),
        .miss_right    (miss_right)
    );

    always_ff @(posedge game_clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ball_x    <= CX;
            ball_y    <= CY;
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            point     <= 1'b0;
            game_over <= 1'b0;
            serve_dir <= 1'b1;
            vx        <= '{mag: 4'(INIT_VX), dir: 1'b1};
            vy        <= '{mag: 4'(INIT_VY), dir: 1'b1};
            hold_cnt  <= '0;
        end else begin
            point <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (serve) begin
                        state <= ST_PLAY;
                        vx    <= '{mag: 4'(INIT_VX), dir: serve_dir};
                        vy    <= '{mag: 4'(INIT_VY), dir: 1'b1};
                    end
                end
                ST_PLAY: begin
                    if (miss_left || miss_right) begin
                        ball_x <= CX;
                        ball_y <= CY;
                        point  <= 1'b1;
                        // Next serve heads toward whoever conceded.
                        if (miss_left) begin
                            score_r   <= score_r_inc;
                            serve_dir <= 1'b0;
                        end else begin
                            score_l   <= score_l_inc;
                            serve_dir <= 1'b1;
                        end
                        if ((miss_left && score_r_inc == WIN) || (miss_right && score_l_inc == WIN)) begin
                            state     <= ST_GAME_OVER;
                            game_over <= 1'b1;
                        end else begin
                            state    <= ST_HOLD;
                            hold_cnt <= HOLD_LOAD;
                        end
                    end else begin
                        // x and y reflections are independent and may coincide.
                        if (hit_left) begin
                            ball_x <= paddle_x_l + PW;
                        end else if (hit_right) begin
                            ball_x <= paddle_x_r - BS;
                        end else begin
                            ball_x <= next_x[9:0];
                        end
                        if (hit_ceil) begin
                            ball_y <= y_ceil + 10'd1;
                            vy.dir <= 1'b1;
                        end else if (hit_floor) begin
                            ball_y <= y_floor - BS - 10'd1;
                            vy.dir <= 1'b0;
                        end else begin
                            ball_y <= next_y[9:0];
                        end
                        if (hit_left || hit_right) begin
                            vx <= '{mag: vx_mag_hit, dir: hit_left};
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                ST_GAME_OVER: begin
                    state <= ST_GAME_OVER;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_collision_controller.sv
// tb/tb_ball_collision_controller.sv - self-checking bench for ball_collision_controller
module tb_ball_collision_controller;

    localparam int CX = 316;
    localparam int CY = 236;
    localparam int BSZ = 8;
    localparam int PWD = 10;
    localparam int IVX = 2;
    localparam int IVY = 1;
    localparam int MVX = 8;
    localparam int HOLD = 60;
    localparam int WIN = 5;

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_HOLD = 2;
    localparam int M_OVER = 3;

    logic       game_clk = 1'b0;
    logic       reset;
    logic       serve;
    logic [9:0] y_ceil, y_floor, x_lwall, x_rwall;
    logic [9:0] paddle_x_l, paddle_y_l, paddle_x_r, paddle_y_r;
    logic [7:0] height_paddle;
    logic [9:0] ball_x, ball_y;
    logic [3:0] score_l, score_r;
    logic       point, game_over;

    int checks = 0;
    int passes = 0;

    // Reference model state: signed velocities, plain integers.
    int m_state, m_x, m_y, m_vx, m_vy, m_sl, m_sr, m_point, m_go, m_hold;
    bit m_serve_right;

    typedef struct {
        int k;
        int exp_x;
        int exp_y;
    } vec_t;
    vec_t tbl[7];

    always #5 game_clk = ~game_clk;

    ball_collision_controller dut (
        .game_clk      (game_clk),
        .reset         (reset),
        .serve         (serve),
        .y_ceil        (y_ceil),
        .y_floor       (y_floor),
        .x_lwall       (x_lwall),
        .x_rwall       (x_rwall),
        .paddle_x_l    (paddle_x_l),
        .paddle_y_l    (paddle_y_l),
        .paddle_x_r    (paddle_x_r),
        .paddle_y_r    (paddle_y_r),
        .height_paddle (height_paddle),
        .ball_x        (ball_x),
        .ball_y        (ball_y),
        .score_l       (score_l),
        .score_r       (score_r),
        .point         (point),
        .game_over     (game_over)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_step();
        int nx, ny, sp, pxl, pyl, pxr, pyr, h;
        bit hl, hr, ml, mr;
        if (reset) begin
            m_state = M_IDLE; m_x = CX; m_y = CY; m_sl = 0; m_sr = 0;
            m_point = 0; m_go = 0; m_serve_right = 1'b1;
            return;
        end
        m_point = 0;
        pxl = int'(paddle_x_l); pyl = int'(paddle_y_l);
        pxr = int'(paddle_x_r); pyr = int'(paddle_y_r);
        h = int'(height_paddle);
        case (m_state)
            M_IDLE: if (serve) begin
                m_state = M_PLAY;
                m_vx = m_serve_right ? IVX : -IVX;
                m_vy = IVY;
            end
            M_PLAY: begin
                nx = m_x + m_vx; if (nx < 0) nx = 0;
                ny = m_y + m_vy; if (ny < 0) ny = 0;
                hl = (m_vx < 0) && (m_x >= pxl + PWD) && (nx < pxl + PWD)
                     && (m_y + BSZ > pyl) && (m_y < pyl + h);
                hr = (m_vx > 0) && (m_x + BSZ <= pxr) && (nx + BSZ > pxr)
                     && (m_y + BSZ > pyr) && (m_y < pyr + h);
                ml = !hl && !hr && (nx <= int'(x_lwall));
                mr = !hl && !hr && !ml && (nx + BSZ >= int'(x_rwall));
                if (ml || mr) begin
                    m_x = CX; m_y = CY; m_point = 1;
                    if (ml) begin
                        if (m_sr < WIN) m_sr++;
                        m_serve_right = 1'b0;
                    end else begin
                        if (m_sl < WIN) m_sl++;
                        m_serve_right = 1'b1;
                    end
                    if (m_sl == WIN || m_sr == WIN) begin
                        m_state = M_OVER; m_go = 1;
                    end else begin
                        m_state = M_HOLD; m_hold = HOLD;
                    end
                end else begin
                    if (ny <= int'(y_ceil)) begin
                        ny = int'(y_ceil) + 1; m_vy = iabs(m_vy);
                    end else if (ny + BSZ >= int'(y_floor)) begin
                        ny = int'(y_floor) - BSZ - 1; m_vy = -iabs(m_vy);
                    end
                    sp = iabs(m_vx);
`ifdef BALL_SPEEDUP_EN
                    if (hl || hr) sp = (sp < MVX) ? sp + 1 : MVX;
`endif
                    if (hl) begin
                        nx = pxl + PWD; m_vx = sp;
                    end else if (hr) begin
                        nx = pxr - BSZ; m_vx = -sp;
                    end
                    m_x = nx; m_y = ny;
                end
            end
            M_HOLD: begin
                m_hold--;
                if (m_hold == 0) m_state = M_IDLE;
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge game_clk);
        model_step();
        #1;
        chk("ball_x", int'(ball_x), m_x);
        chk("ball_y", int'(ball_y), m_y);
        chk("score_l", int'(score_l), m_sl);
        chk("score_r", int'(score_r), m_sr);
        chk("point", int'(point), m_point);
        chk("game_over", int'(game_over), m_go);
    endtask

    task automatic wait_play(input int limit, input string tag);
        int n = 0;
        while (m_state != M_PLAY && n < limit) begin tick(); n++; end
        if (m_state != M_PLAY) begin
            checks++;
            $display("FAIL %s: serve not accepted within %0d ticks", tag, limit);
        end
    endtask

    task automatic run_until_point(input int limit, input string tag);
        int n = 0;
        while (m_point == 0 && n < limit) begin tick(); n++; end
        if (m_point == 0) begin
            checks++;
            $display("FAIL %s: no point within %0d ticks", tag, limit);
        end
    endtask

    initial begin
        int k;
        int n;
        tbl[0] = '{1, 318, 237};
        tbl[1] = '{2, 320, 238};
        tbl[2] = '{10, 336, 246};
        tbl[3] = '{50, 416, 286};
        tbl[4] = '{143, 602, 379};
        tbl[5] = '{144, 602, 380};
`ifdef BALL_SPEEDUP_EN
        tbl[6] = '{145, 599, 381};
`else
        tbl[6] = '{145, 600, 381};
`endif

        reset = 1'b1; serve = 1'b0;
        y_ceil = 10'd0; y_floor = 10'd479; x_lwall = 10'd0; x_rwall = 10'd639;
        paddle_x_l = 10'd20; paddle_y_l = 10'd0; paddle_x_r = 10'd610; paddle_y_r = 10'd340;
        height_paddle = 8'd80;

        tick(); tick();
        chk("rst_x", int'(ball_x), 316);
        chk("rst_y", int'(ball_y), 236);
        chk("rst_point", int'(point), 0);
        chk("rst_go", int'(game_over), 0);
        reset = 1'b0;
        tick();
        chk("idle_frozen_x", int'(ball_x), 316);

        // Serve, straight-line flight, then a right paddle bounce.
        serve = 1'b1; tick(); serve = 1'b0;
        chk("serve_latency_x", int'(ball_x), 316);
        k = 0;
        for (int i = 0; i < 7; i++) begin
            while (k < tbl[i].k) begin tick(); k++; end
            chk($sformatf("tbl%0d_x", i), int'(ball_x), tbl[i].exp_x);
            chk($sformatf("tbl%0d_y", i), int'(ball_y), tbl[i].exp_y);
        end

        // One point, then reset in the middle of the next rally.
        reset = 1'b1; tick(); reset = 1'b0;
        paddle_y_r = 10'd0;
        serve = 1'b1; wait_play(10, "first_serve"); serve = 1'b0;
        run_until_point(400, "first_miss");
        chk("first_miss_score_l", int'(score_l), 1);
        chk("first_miss_point", int'(point), 1);
        serve = 1'b1; wait_play(100, "hold_then_serve"); serve = 1'b0;
        n = 0;
        while (m_x != 400 && n < 200) begin tick(); n++; end
        chk("reach_400", int'(ball_x), 400);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("midrst_x", int'(ball_x), 316);
        chk("midrst_y", int'(ball_y), 236);
        chk("midrst_score_l", int'(score_l), 0);
        tick();
        chk("midrst_idle_x", int'(ball_x), 316);

        // Five right-side misses end the game.
        for (int i = 1; i <= 5; i++) begin
            serve = 1'b1; wait_play(100, "go_serve"); serve = 1'b0;
            run_until_point(400, "go_miss");
            chk($sformatf("go_score_l_%0d", i), int'(score_l), i);
        end
        chk("go_level", int'(game_over), 1);
        serve = 1'b1;
        repeat (20) tick();
        serve = 1'b0;
        chk("go_serve_ignored_x", int'(ball_x), 316);
        chk("go_still_over", int'(game_over), 1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("go_reset_score_l", int'(score_l), 0);
        chk("go_reset_over", int'(game_over), 0);

        // Randomised play against the reference model.
        for (int t = 0; t < 20000; t++) begin
            int r;
            if ($urandom_range(0, 1) == 1) begin
                r = m_y - int'($urandom_range(0, 85));
                paddle_y_l = 10'((r < 0) ? 0 : r);
                r = m_y - int'($urandom_range(0, 85));
                paddle_y_r = 10'((r < 0) ? 0 : r);
            end else begin
                paddle_y_l = 10'($urandom_range(0, 399));
                paddle_y_r = 10'($urandom_range(0, 399));
            end
            height_paddle = 8'($urandom_range(40, 120));
            serve = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 3999) == 0)
                    || (m_state == M_OVER && $urandom_range(0, 19) == 0);
            tick();
        end
        reset = 1'b0; serve = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
